mac_dot_seq: RTL and testbench
==============================

MAC_DOT_SEQ -- requirements
Module: mac_dot_seq

Interface
REQ-001 SHALL provide parameter LEN_W, default 16, width of the job length.
REQ-002 SHALL provide parameter MAC_LAT, default 4, part4_mac input-to-output latency in cycles (used only for bench and assertions).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle job request; sampled only in IDLE.
REQ-006 SHALL have port len  input  LEN_W  number of operand pairs; captured with start.
REQ-007 SHALL have port in_valid  input  1  operand pair present.
REQ-008 SHALL have port in_ready  output  1  sequencer accepts the pair this cycle.
REQ-009 SHALL have port in_a  input  14  signed operand a.
REQ-010 SHALL have port in_b  input  14  signed operand b.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse; result is valid.
REQ-013 SHALL have port result  output  28  signed dot product, saturated by part4_mac.

Function
REQ-014 SHALL implement the FSM states IDLE, CLEAR, STREAM, DRAIN and DONE.
REQ-015 IDLE: start=1 SHALL capture len into len_q, zero issue_cnt and ret_cnt, and go to CLEAR; start=0 SHALL stay in IDLE.
REQ-016 CLEAR SHALL drive the part4_mac reset high for exactly one cycle to zero its accumulator and pipeline, then go to STREAM if len_q>0, else go to DONE.
REQ-017 STREAM: in_ready SHALL be high exactly when issue_cnt<len_q; in_ready SHALL be low in all other states.
REQ-018 Each cycle with in_valid && in_ready SHALL drive mac valid_in=1 with a=in_a, b=in_b in that cycle, and increment issue_cnt.
REQ-019 When no transfer occurs, mac valid_in SHALL be 0; in_valid bubbles SHALL NOT change the result.
REQ-020 STREAM SHALL go to DRAIN in the cycle after issue_cnt reaches len_q.
REQ-021 ret_cnt SHALL increment on every mac valid_out while in STREAM or DRAIN, since part4_mac emits one valid_out per valid_in.
REQ-022 In the cycle where valid_out raises ret_cnt to len_q, result SHALL be loaded from mac f and the FSM SHALL go to DONE; this SHALL hold even if still in STREAM.
REQ-023 DONE SHALL assert done for one cycle and then go to IDLE; the total DONE-to-next-start turnaround is 1 cycle.
REQ-024 For len=0, result SHALL be 0 and done SHALL pulse 2 cycles after start (CLEAR, then DONE).
REQ-025 result SHALL hold its value until the next job's DONE load; it SHALL NOT be cleared by a new start.
REQ-026 start asserted while busy SHALL be ignored; a new len SHALL NOT be captured.
REQ-027 Accumulation and saturation SHALL be performed solely by part4_mac; there SHALL be no extra arithmetic on f.
REQ-028 Minimum job latency SHALL be: last accepted pair to done = MAC_LAT+1 cycles.

Reset
REQ-029 reset=1 SHALL force IDLE, busy=0, in_ready=0, done=0, result=0, and all counters to 0.
REQ-030 The part4_mac reset SHALL be reset OR (state==CLEAR).
REQ-031 reset asserted mid-job SHALL abandon the job with no done pulse; the next job SHALL be unaffected by the abandoned job.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the operand width 14 and the accumulator width 28.
REQ-033 Exactly one sub-module SHALL be instantiated: part4_mac, with no modifications.

Verification
REQ-034 Basic: len=3, pairs (2,3),(4,5),(-1,7) -> one done pulse, result=19.
REQ-035 Empty job: len=0 -> done 2 cycles after start, result=0, in_ready never high.
REQ-036 Saturation: len=10, a=b=8191 each pair -> result=0x7FFFFFF; with a=-8192, b=8191 -> result=0x8000000.
REQ-037 Back-to-back with bubbles: job1 len=4 of (100,100) with in_valid toggling -> 40000; immediately start job2 len=1 (1,1) -> 1 (accumulator cleared).
REQ-038 Reset mid-STREAM after 2 of 5 pairs -> busy=0 next cycle, no done pulse; then len=2 (3,3),(3,3) -> result=18.
REQ-039 start pulsed during STREAM with len=7 -> ignored; original job completes with its original len.

Source files
------------

// File: rtl/mac_dot_seq_pkg.sv
// mac_dot_seq_pkg: shared widths, FSM state enum and the saturating add used by part4_mac
package mac_dot_seq_pkg;
  localparam int OP_W = 14;
  localparam int ACC_W = 28;
  typedef enum logic [2:0] {ST_IDLE, ST_CLEAR, ST_STREAM, ST_DRAIN, ST_DONE} state_t;
  function automatic logic signed [ACC_W-1:0] sat_add(input logic signed [ACC_W-1:0] x, input logic signed [ACC_W-1:0] y);
    logic [ACC_W:0] s;
    s = {x[ACC_W-1], x} + {y[ACC_W-1], y};
    return s[ACC_W] != s[ACC_W-1] ? (s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}}) : s[ACC_W-1:0];
  endfunction
endpackage

// File: rtl/mac_dot_seq_if.sv
// mac_dot_seq_if: job/stream bus (start,len,in_valid,in_a,in_b in; in_ready,busy,done,result out of the slave)
interface mac_dot_seq_if import mac_dot_seq_pkg::*; #(parameter int LEN_W = 16);
  logic start;
  logic [LEN_W-1:0] len;
  logic in_valid;
  logic in_ready;
  logic signed [OP_W-1:0] in_a;
  logic signed [OP_W-1:0] in_b;
  logic busy;
  logic done;
  logic signed [ACC_W-1:0] result;
  modport master (output start, len, in_valid, in_a, in_b, input in_ready, busy, done, result);
  modport slave (input start, len, in_valid, in_a, in_b, output in_ready, busy, done, result);
endinterface

// File: rtl/mac_dot_seq_mac.sv
// part4_mac: 4-cycle pipelined saturating MAC; ports clk, reset (clears pipe+acc), valid_in/a/b in, valid_out/f out
module part4_mac import mac_dot_seq_pkg::*; (
  input  logic clk,
  input  logic reset,
  input  logic valid_in,
  input  logic signed [OP_W-1:0] a,
  input  logic signed [OP_W-1:0] b,
  output logic valid_out,
  output logic signed [ACC_W-1:0] f
);
  logic signed [OP_W-1:0] a1, b1;
  logic signed [ACC_W-1:0] p2, acc;
  logic v1, v2, v3;
  always_ff @(posedge clk) begin
    if (reset) begin
      a1 <= '0;
      b1 <= '0;
      p2 <= '0;
      acc <= '0;
      f <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      a1 <= a;
      b1 <= b;
      v1 <= valid_in;
      p2 <= ACC_W'(a1) * ACC_W'(b1);
      v2 <= v1;
      if (v2) acc <= sat_add(acc, p2);
      v3 <= v2;
      f <= acc;
      valid_out <= v3;
    end
  end
endmodule

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: sequences one dot-product job through part4_mac; ports clk, reset, bus (mac_dot_seq_if.slave)
module mac_dot_seq import mac_dot_seq_pkg::*; #(
  parameter int LEN_W = 16,
  parameter int MAC_LAT = 4
) (
  input logic clk,
  input logic reset,
  mac_dot_seq_if.slave bus
);
  state_t state;
  logic [LEN_W-1:0] len_q, issue_cnt, ret_cnt;
  logic mac_rst, mac_vout, fire, ret_last;
  logic signed [ACC_W-1:0] mac_f;
  logic [MAC_LAT-1:0] vin_hist;
  assign bus.in_ready = state == ST_STREAM && issue_cnt < len_q;
  assign fire = bus.in_valid && bus.in_ready;
  assign mac_rst = reset || state == ST_CLEAR;
  assign ret_last = mac_vout && (state == ST_STREAM || state == ST_DRAIN) && ret_cnt + LEN_W'(1) == len_q;
  part4_mac u_mac (
    .clk(clk),
    .reset(mac_rst),
    .valid_in(fire),
    .a(bus.in_a),
    .b(bus.in_b),
    .valid_out(mac_vout),
    .f(mac_f)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      len_q <= '0;
      issue_cnt <= '0;
      ret_cnt <= '0;
      bus.result <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (fire) issue_cnt <= issue_cnt + LEN_W'(1);
      if (mac_vout && (state == ST_STREAM || state == ST_DRAIN)) ret_cnt <= ret_cnt + LEN_W'(1);
      case (state)
        ST_IDLE: if (bus.start) begin
          len_q <= bus.len;
          issue_cnt <= '0;
          ret_cnt <= '0;
          bus.busy <= 1'b1;
          state <= ST_CLEAR;
        end
        ST_CLEAR: if (len_q == '0) begin
          bus.result <= '0;
          bus.done <= 1'b1;
          state <= ST_DONE;
        end else state <= ST_STREAM;
        ST_STREAM, ST_DRAIN: if (ret_last) begin
          bus.result <= mac_f;
          bus.done <= 1'b1;
          state <= ST_DONE;
        end else if (state == ST_STREAM && issue_cnt == len_q) state <= ST_DRAIN;
        default: begin
          bus.busy <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end
  // every issued pair must come back exactly MAC_LAT cycles later unless the MAC was cleared meanwhile
  always_ff @(posedge clk) begin
    vin_hist <= mac_rst ? '0 : {vin_hist[MAC_LAT-2:0], fire};
    if (!mac_rst) assert (mac_vout == vin_hist[MAC_LAT-1]);
  end
endmodule

// File: tb/tb_mac_dot_seq.sv
module tb_mac_dot_seq;
  localparam int MAC_LAT = 4;
  localparam longint SMAX = 134217727;
  localparam longint SMIN = -134217728;
  typedef struct {
    int n;
    int bub;
    logic [15:0][13:0] a;
    logic [15:0][13:0] b;
    longint exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_chk = 0;
  int n_fail = 0;
  mac_dot_seq_if #(.LEN_W(16)) bus();
  mac_dot_seq #(.LEN_W(16), .MAC_LAT(MAC_LAT)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm, got, exp);
    end
  endtask

  function automatic vec_t uni(input int n, input int a, input int b, input int bub, input longint exp);
    vec_t v;
    v.n = n;
    v.bub = bub;
    v.exp = exp;
    for (int i = 0; i < 16; i++) begin
      v.a[i] = 14'(a);
      v.b[i] = 14'(b);
    end
    return v;
  endfunction

  function automatic longint ref_dot(input int n, input logic [15:0][13:0] aa, input logic [15:0][13:0] bb);
    longint acc = 0;
    for (int i = 0; i < n; i++) begin
      acc += longint'($signed(aa[i])) * longint'($signed(bb[i]));
      acc = acc > SMAX ? SMAX : acc < SMIN ? SMIN : acc;
    end
    return acc;
  endfunction

  task automatic run_job(input int n, input logic [15:0][13:0] aa, input logic [15:0][13:0] bb, input int bub,
                         input int pulse, output longint res, output int dcnt, output int dcyc, output int lat,
                         output int rdy, output int acc_n);
    int cyc, last;
    acc_n = 0; last = 0; dcnt = 0; dcyc = 0; rdy = 0; res = 0;
    @(negedge clk);
    chk("idle_busy", longint'(bus.busy), 0);
    chk("idle_done", longint'(bus.done), 0);
    bus.start = 1'b1;
    bus.len = 16'(n);
    @(negedge clk);
    chk("busy_on", longint'(bus.busy), 1);
    cyc = 1;
    while (cyc < 300 && dcnt == 0) begin
      bus.start = cyc == pulse;
      bus.len = 16'(3);
      if (bus.done) begin
        dcnt = 1;
        dcyc = cyc;
        res = bus.result;
      end else begin
        bus.in_valid = acc_n < n && (bub == 0 || $urandom_range(0, 1) == 1);
        bus.in_a = acc_n < 16 ? aa[acc_n] : '0;
        bus.in_b = acc_n < 16 ? bb[acc_n] : '0;
        if (bus.in_ready) rdy++;
        if (bus.in_valid && bus.in_ready) begin
          acc_n++;
          last = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    lat = dcyc - last;
  endtask

  task automatic do_job(input string nm, input int n, input logic [15:0][13:0] aa, input logic [15:0][13:0] bb,
                        input int bub, input int pulse, input longint exp);
    longint res;
    int dcnt, dcyc, lat, rdy, acc_n;
    run_job(n, aa, bb, bub, pulse, res, dcnt, dcyc, lat, rdy, acc_n);
    chk({nm, "_done"}, dcnt, 1);
    chk({nm, "_result"}, res, exp);
    chk({nm, "_pairs"}, acc_n, n);
    if (n > 0) chk({nm, "_latency"}, lat, MAC_LAT + 1);
    else begin
      chk({nm, "_done_cyc"}, dcyc, 2);
      chk({nm, "_ready"}, rdy, 0);
    end
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int k, dn;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0;
    tbl[0] = uni(3, 0, 0, 0, 19);
    tbl[0].a[0] = 14'(2); tbl[0].b[0] = 14'(3);
    tbl[0].a[1] = 14'(4); tbl[0].b[1] = 14'(5);
    tbl[0].a[2] = 14'(-1); tbl[0].b[2] = 14'(7);
    tbl[1] = uni(10, 8191, 8191, 0, SMAX);
    tbl[2] = uni(10, -8192, 8191, 0, SMIN);
    tbl[3] = uni(4, 100, 100, 1, 40000);
    tbl[4] = uni(1, 1, 1, 0, 1);
    tbl[5] = uni(0, 5, 5, 0, 0);
    tbl[6] = uni(16, -8192, -8192, 1, SMAX);
    tbl[7] = uni(2, 8191, 8191, 0, -8191);
    tbl[7].a[1] = 14'(-8192);
    repeat (3) @(negedge clk);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_ready", longint'(bus.in_ready), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_result", bus.result, 0);
    reset = 1'b0;
    for (int i = 0; i < 8; i++) do_job($sformatf("vec%0d", i), tbl[i].n, tbl[i].a, tbl[i].b, tbl[i].bub, 0, tbl[i].exp);
    // start pulse mid-stream must not restart the job or recapture len
    v = uni(7, 2, 3, 0, 42);
    do_job("start_ignored", v.n, v.a, v.b, 0, 4, 42);
    // reset after 2 of 5 pairs: job abandoned silently
    @(negedge clk);
    bus.start = 1'b1; bus.len = 16'(5);
    @(negedge clk);
    bus.start = 1'b0;
    k = 0;
    for (int c = 0; c < 50 && k < 2; c++) begin
      bus.in_valid = 1'b1; bus.in_a = 14'(7); bus.in_b = 14'(7);
      if (bus.in_ready) k++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    chk("abort_fed", k, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", longint'(bus.busy), 0);
    chk("abort_ready", longint'(bus.in_ready), 0);
    chk("abort_result", bus.result, 0);
    dn = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus.done) dn++;
      @(negedge clk);
    end
    chk("abort_no_done", dn, 0);
    v = uni(2, 3, 3, 0, 18);
    do_job("after_abort", v.n, v.a, v.b, 0, 0, 18);
    for (int r = 0; r < 12; r++) begin
      v.n = $urandom_range(0, 12);
      v.bub = $urandom_range(0, 1);
      for (int i = 0; i < 16; i++) begin
        v.a[i] = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? 14'(8191) : 14'(-8192)) : 14'($urandom);
        v.b[i] = $urandom_range(0, 3) == 0 ? ($urandom_range(0, 1) == 1 ? 14'(8191) : 14'(-8192)) : 14'($urandom);
      end
      do_job($sformatf("rand%0d", r), v.n, v.a, v.b, v.bub, 0, ref_dot(v.n, v.a, v.b));
    end
    @(negedge clk);
    chk("final_done_low", longint'(bus.done), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
